// File: rtl/mux_scan_serializer_if.sv
`default_nettype none
// ============================================================================
//  Module   : mux_scan_serializer_if
//  Brief    : Upstream handshake, mux drive/return and serial output bundle.
//  Revision : 1.0
// ============================================================================
interface mux_scan_serializer_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] d;
    logic [2:0] s;
    logic       y;
    logic       ser_out;
    logic       ser_valid;
    logic       ser_last;
    logic       busy;

    // master: the serializer itself; slave: word source, mux and serial sink
    modport master (
        input  in_data, in_valid, y,
        output in_ready, d, s, ser_out, ser_valid, ser_last, busy
    );
    modport slave (
        output in_data, in_valid, y,
        input  in_ready, d, s, ser_out, ser_valid, ser_last, busy
    );
endinterface
`default_nettype wire

// File: rtl/mux_scan_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : mux_scan_serializer
//  Brief    : Steps an 8:1 mux select over a held word, LSB-first serial out.
//             SCAN_PARITY_EN appends an even-parity 9th bit.
//  Revision : 1.0
// ============================================================================
module mux_scan_serializer #(
    parameter int BIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mux_scan_serializer_if.master bus
);
    localparam int                 c_DIV_W    = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(BIT_CYCLES - 1);
    localparam logic [c_DIV_W-1:0] c_DIV_ONE  = c_DIV_W'(1);
    localparam logic [2:0]         c_S_LAST   = 3'd7;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_SHIFT = 2'd1;
`ifdef SCAN_PARITY_EN
    localparam logic [1:0] c_ST_PARITY     = 2'd2;
    localparam logic [1:0] c_ST_AFTER_DATA = c_ST_PARITY;
    localparam logic       c_LAST_ON_DATA  = 1'b0;
`else
    localparam logic [1:0] c_ST_AFTER_DATA = c_ST_IDLE;
    localparam logic       c_LAST_ON_DATA  = 1'b1;
`endif

    logic [1:0]         state_q,     state_d;
    logic [7:0]         d_q,         d_d;
    logic [2:0]         s_q,         s_d;
    logic [c_DIV_W-1:0] divider_q,   divider_d;
    logic               ser_out_q,   ser_out_d;
    logic               ser_valid_q, ser_valid_d;
    logic               ser_last_q,  ser_last_d;

    logic w_bit_done;
    assign w_bit_done = (divider_q == c_DIV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= c_ST_IDLE;
            d_q         <= 8'd0;
            s_q         <= 3'd0;
            divider_q   <= '0;
            ser_out_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            ser_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            d_q         <= d_d;
            s_q         <= s_d;
            divider_q   <= divider_d;
            ser_out_q   <= ser_out_d;
            ser_valid_q <= ser_valid_d;
            ser_last_q  <= ser_last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_ST_IDLE:  if (bus.in_valid) state_d = c_ST_SHIFT;
            c_ST_SHIFT: if (w_bit_done && (s_q == c_S_LAST)) state_d = c_ST_AFTER_DATA;
`ifdef SCAN_PARITY_EN
            c_ST_PARITY: if (w_bit_done) state_d = c_ST_IDLE;
`endif
            default:    state_d = c_ST_IDLE;
        endcase
    end

    // y is sampled in the same cycle its select is presented on s
    always_comb begin
        d_d         = d_q;
        s_d         = s_q;
        divider_d   = divider_q;
        ser_out_d   = ser_out_q;
        ser_valid_d = 1'b0;
        ser_last_d  = 1'b0;
        case (state_q)
            c_ST_IDLE: begin
                if (bus.in_valid) begin
                    d_d       = bus.in_data;
                    s_d       = 3'd0;
                    divider_d = '0;
                end
            end
            c_ST_SHIFT: begin
                if (w_bit_done) begin
                    ser_out_d   = bus.y;
                    ser_valid_d = 1'b1;
                    divider_d   = '0;
                    s_d         = (s_q == c_S_LAST) ? 3'd0 : s_q + 3'd1;
                    ser_last_d  = c_LAST_ON_DATA && (s_q == c_S_LAST);
                end else begin
                    divider_d = divider_q + c_DIV_ONE;
                end
            end
`ifdef SCAN_PARITY_EN
            c_ST_PARITY: begin
                if (w_bit_done) begin
                    ser_out_d   = ^d_q;
                    ser_valid_d = 1'b1;
                    ser_last_d  = 1'b1;
                    divider_d   = '0;
                end else begin
                    divider_d = divider_q + c_DIV_ONE;
                end
            end
`endif
            default: begin
                s_d       = 3'd0;
                divider_d = '0;
            end
        endcase
    end

    assign bus.in_ready  = (state_q == c_ST_IDLE);
    assign bus.busy      = (state_q != c_ST_IDLE);
    assign bus.d         = d_q;
    assign bus.s         = s_q;
    assign bus.ser_out   = ser_out_q;
    assign bus.ser_valid = ser_valid_q;
    assign bus.ser_last  = ser_last_q;
endmodule
`default_nettype wire

// File: tb/tb_mux_scan_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mux_scan_serializer
//  Brief    : Directed + random frames on BIT_CYCLES=1 and =4 instances.
//  Revision : 1.0
// ============================================================================
module tb_mux_scan_serializer;
`ifdef SCAN_PARITY_EN
    localparam int c_NBITS = 9;
`else
    localparam int c_NBITS = 8;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       dsel;
    logic       drv_valid;
    logic [7:0] drv_data;
    logic       last_ser [2];
    int         checks   = 0;
    int         failures = 0;

    mux_scan_serializer_if bus1();
    mux_scan_serializer_if bus4();

    assign bus1.in_data  = drv_data;
    assign bus4.in_data  = drv_data;
    assign bus1.in_valid = drv_valid & ~dsel;
    assign bus4.in_valid = drv_valid & dsel;
    // the 8:1 mux being sequenced
    assign bus1.y = bus1.d[bus1.s];
    assign bus4.y = bus4.d[bus4.s];

    mux_scan_serializer #(.BIT_CYCLES(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    mux_scan_serializer #(.BIT_CYCLES(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

    always #5 clk = ~clk;

    wire [7:0] w_d         = dsel ? bus4.d         : bus1.d;
    wire [2:0] w_s         = dsel ? bus4.s         : bus1.s;
    wire       w_in_ready  = dsel ? bus4.in_ready  : bus1.in_ready;
    wire       w_busy      = dsel ? bus4.busy      : bus1.busy;
    wire       w_ser_out   = dsel ? bus4.ser_out   : bus1.ser_out;
    wire       w_ser_valid = dsel ? bus4.ser_valid : bus1.ser_valid;
    wire       w_ser_last  = dsel ? bus4.ser_last  : bus1.ser_last;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_vals(input string tag);
        chk({tag, "_in_ready"}, w_in_ready, 1);
        chk({tag, "_busy"},     w_busy, 0);
        chk({tag, "_s"},        w_s, 0);
        chk({tag, "_d"},        w_d, 0);
        chk({tag, "_ser_out"},  w_ser_out, 0);
        chk({tag, "_ser_valid"}, w_ser_valid, 0);
        chk({tag, "_ser_last"}, w_ser_last, 0);
    endtask

    // Called at a negedge with the selected DUT idle; returns at the negedge after the accept edge.
    task automatic start_frame(input logic [7:0] w);
        chk("ready_before_accept", w_in_ready, 1);
        drv_data  = w;
        drv_valid = 1'b1;
        @(negedge clk);
        drv_valid = 1'b0;
    endtask

    // Reference: bit k of the frame is w[k] (k<8) or ^w, strobed k+1 bit periods after the accept.
    task automatic run_frame(input logic [7:0] w, input int bc, input bit noisy,
                             input bit hold, input logic [7:0] nxt);
        int   k;
        logic strobe;
        logic exp_bit;
        chk("d_load", w_d, w);
        chk("s_load", w_s, 0);
        chk("busy_start", w_busy, 1);
        chk("ready_start", w_in_ready, 0);
        if (hold) begin
            drv_valid = 1'b1;
            drv_data  = nxt;
        end
        for (int n = 1; n <= c_NBITS * bc; n++) begin
            if (noisy) begin
                drv_valid = 1'($urandom);
                drv_data  = 8'($urandom);
            end
            @(negedge clk);
            strobe = ((n % bc) == 0);
            chk("ser_valid", w_ser_valid, strobe);
            if (strobe) begin
                k       = n / bc - 1;
                exp_bit = (k < 8) ? w[k] : ^w;
                last_ser[dsel] = exp_bit;
                chk("ser_last", w_ser_last, (k == c_NBITS - 1));
            end else begin
                chk("ser_last_quiet", w_ser_last, 0);
            end
            chk("ser_out", w_ser_out, last_ser[dsel]);
            chk("sel", w_s, (n < 8 * bc) ? (n / bc) : 0);
            chk("d_hold", w_d, w);
            chk("busy", w_busy, (n < c_NBITS * bc));
            chk("in_ready", w_in_ready, (n == c_NBITS * bc));
        end
        if (!hold) drv_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] w;
        dsel        = 1'b0;
        drv_valid   = 1'b0;
        drv_data    = 8'd0;
        rst_n       = 1'b0;
        last_ser[0] = 1'b0;
        last_ser[1] = 1'b0;

        repeat (3) @(negedge clk);
        reset_vals("rst1_hold");
        dsel = 1'b1; #1;
        reset_vals("rst4_hold");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        reset_vals("rst4_rel");
        dsel = 1'b0; #1;
        reset_vals("rst1_rel");

        // Directed 8'hAD frame at one cycle per bit
        @(negedge clk);
        start_frame(8'hAD);
        run_frame(8'hAD, 1, 1'b0, 1'b0, 8'h00);

        // Four cycles per bit
        dsel = 1'b1; #1;
        @(negedge clk);
        start_frame(8'hF0);
        run_frame(8'hF0, 4, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            w = 8'($urandom);
            start_frame(w);
            run_frame(w, 4, 1'b1, 1'b0, 8'h00);
        end

        // Back-to-back with in_valid held high
        dsel = 1'b0; #1;
        @(negedge clk);
        start_frame(8'h01);
        run_frame(8'h01, 1, 1'b0, 1'b1, 8'h80);
        @(negedge clk);
        drv_valid = 1'b0;
        run_frame(8'h80, 1, 1'b0, 1'b0, 8'h00);

        // Random words with in_valid noise while busy
        for (int i = 0; i < 6; i++) begin
            w = 8'($urandom);
            start_frame(w);
            run_frame(w, 1, 1'b1, 1'b0, 8'h00);
        end

        // Reset after the third strobe of 8'hFF
        start_frame(8'hFF);
        for (int n = 1; n <= 3; n++) begin
            @(negedge clk);
            chk("abort_ser_valid", w_ser_valid, 1);
            chk("abort_ser_last", w_ser_last, 0);
        end
        rst_n = 1'b0;
        #1;
        last_ser[0] = 1'b0;
        last_ser[1] = 1'b0;
        reset_vals("abort_now");
        @(negedge clk);
        reset_vals("abort_held");
        rst_n = 1'b1;
        @(negedge clk);
        reset_vals("abort_rel");
        start_frame(8'h55);
        run_frame(8'h55, 1, 1'b0, 1'b0, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/mux_scan_serializer.md
# mux_scan_serializer

Upstream sequencer for the 8-to-1 mux. It accepts an 8-bit word over a valid/ready handshake and holds it on the mux data inputs. It then steps the 3-bit select from 0 to 7 and samples the mux output back, producing an LSB-first serial bitstream with a per-bit valid strobe and an end-of-frame marker. It wraps the existing combinational mux into a parallel-to-serial transmit stage.

## Interface
- BIT_CYCLES, 1, clock cycles per serial bit; legal range 1..256; 0 is illegal.
- clk  in  1  rising-edge clock; the block's only clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_data  in  8  word to serialize.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block can accept a word; combinational, `state==IDLE`.
- d  out  8  held word, wired to the mux data input; registered.
- s  out  3  mux select; registered.
- y  in  1  mux output, returned from the mux; combinational function of d and s.
- ser_out  out  1  serial data bit; registered.
- ser_valid  out  1  one-cycle strobe: ser_out holds a new bit.
- ser_last  out  1  asserted with ser_valid on the final bit of a frame.
- busy  out  1  frame in progress; `state!=IDLE`.

## Operation
- Reset values: d=0, s=0, ser_out=0, ser_valid=0, ser_last=0, busy=0, in_ready=1, state=IDLE, divider=0.
- States: IDLE, SHIFT, plus PARITY when the parity macro is defined.
- IDLE
  - On in_valid && in_ready: d<=in_data, s<=0, divider<=0, go to SHIFT.
  - If in_valid is low, stay in IDLE and leave d unchanged.
- SHIFT: divider counts 0..BIT_CYCLES-1. When divider==BIT_CYCLES-1:
  - ser_out<=y and ser_valid<=1 for one cycle.
  - divider<=0.
  - If s!=7: s<=s+1.
  - If s==7: s<=0, and the next state is IDLE (macro off) or PARITY (macro on). ser_last<=1 only when the macro is off.
- PARITY: after a full BIT_CYCLES period, ser_out<=^d (even parity), ser_valid<=1, ser_last<=1, go to IDLE.
- Bit order on ser_out: d[0] first, d[7] last.
- d holds the last word after a frame until the next accept. s is 0 in IDLE.
- ser_valid and ser_last are low on every cycle without a strobe. ser_out keeps its last value between strobes.
- in_valid is ignored while busy. The word is not queued, and the upstream source must keep in_valid high until the handshake.
- Reset mid-frame: abort immediately and return all outputs to their reset values. No ser_last is issued for the aborted frame.

## Timing
- Accept edge E0 loads d and s=0.
- The first bit is on ser_out with ser_valid high after edge E0+BIT_CYCLES.
- Bit k (0..7) is strobed after edge E0+(k+1)*BIT_CYCLES.
- Macro off:
  - ser_last is issued with bit 7 at E0+8*BIT_CYCLES; in_ready=1 in the cycle after that edge.
  - Earliest next accept is edge E0+8*BIT_CYCLES+1, giving a period of 8*BIT_CYCLES+1 cycles per word.
- Macro on:
  - The parity bit is strobed at E0+9*BIT_CYCLES.
  - The period is 9*BIT_CYCLES+1 cycles per word.
- y is sampled in the same cycle as the s value that selects it. y must settle combinationally within one cycle of d and s changing; there is no extra pipeline stage.

## Configuration
- SCAN_PARITY_EN
  - Defined: the PARITY state is compiled in. A 9th bit equal to the XOR of d[7:0] is appended, and ser_last moves from bit 7 to the parity bit.
  - Undefined: the PARITY state and its logic are absent, frames are 8 bits, and ser_last is on bit 7.

## Test plan
- Reset, BIT_CYCLES=1: hold rst_n=0, then release → in_ready=1, busy=0, s=0, d=0, ser_valid=0.
- Frame, BIT_CYCLES=1, macro off: in_data=8'b1010_1101 with one-cycle in_valid →
  - 8 consecutive strobes with ser_out = 1,0,1,1,0,1,0,1.
  - ser_last only on the 8th strobe.
  - in_ready returns on the following cycle.
- Same frame with SCAN_PARITY_EN defined → 9th strobe has ser_out=1 and ser_last=1; no ser_last on the 8th strobe.
- BIT_CYCLES=4, in_data=8'hF0 → strobes every 4 cycles; ser_out = 0,0,0,0,1,1,1,1; s holds each value for 4 cycles.
- Back-to-back, BIT_CYCLES=1: in_valid held high with 8'h01 then 8'h80 → second accept one cycle after the first ser_last; in_valid pulses while busy are ignored.
- Reset mid-frame: assert rst_n=0 after the 3rd strobe of 8'hFF → all outputs go to reset values at once; no ser_last; after release, a new frame 8'h55 serializes correctly.
